// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared definitions for the data-memory controller:
//     - dmem_state_t : FSM state encoding (IDLE / WAIT / RESP)
//     - MAX_WAIT_CYC : largest supported number of wait states
//     - cnt_width()  : width of the wait-state counter for a given wait count
//   No ports; imported by dmem_ctrl and dmem_ws_counter users.
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int MAX_WAIT_CYC = 15;

    // Width needed to hold the value wait_cyc, never less than one bit so
    // that a zero-wait configuration still yields a legal vector.
    function automatic int cnt_width(input int wait_cyc);
        int w;
        w = $clog2(wait_cyc + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_ws_counter.sv
// -----------------------------------------------------------------------------
// dmem_ws_counter
//   Loadable down-counter that paces the wait states of one memory access.
//   The controller loads it with the wait-state count when it accepts a
//   request and decrements it once per cycle while waiting; 'one' tells the
//   controller that the current cycle is the last wait state.
//
//   Ports
//     clk      in   1   clock, rising edge
//     rst      in   1   asynchronous active-low reset, clears the count
//     load     in   1   load load_val (takes priority over dec)
//     dec      in   1   decrement by one, saturating at zero
//     load_val in   W   value to load
//     one      out  1   count currently equals 1
// -----------------------------------------------------------------------------
module dmem_ws_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         one
);

    logic [W-1:0] count;

    // The count never wraps: decrementing is blocked at zero so a stray
    // dec outside an access cannot make the counter run away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign one = (count == W'(1));

endmodule

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
//   Data-memory controller between the core's load/store port and an on-chip
//   RAM array. One access at a time, with a programmable number of wait
//   states between accepting a request and reporting completion, and an
//   out-of-range check that suppresses accesses beyond DEPTH.
//
//   Parameters
//     DATA_W   data word width
//     ADDR_W   word address width
//     DEPTH    implemented words (1 .. 2**ADDR_W)
//     WAIT_CYC wait states between accept and response (0 .. MAX_WAIT_CYC)
//
//   Ports
//     clk    in   1       clock, rising edge
//     rst    in   1       asynchronous active-low reset
//     req    in   1       access request, taken when ready=1
//     we     in   1       1 = write, 0 = read
//     addr   in   ADDR_W  word address
//     wdata  in   DATA_W  write data
//     ready  out  1       idle, a request is accepted this cycle
//     done   out  1       one-cycle completion pulse
//     rdata  out  DATA_W  read data, valid with done on reads, then held
//     err    out  1       with done: address was out of range
// -----------------------------------------------------------------------------
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    // An out-of-range WAIT_CYC is clamped rather than silently truncated
    // by the counter width.
    localparam int WAIT_EFF = (WAIT_CYC > MAX_WAIT_CYC) ? MAX_WAIT_CYC :
                              ((WAIT_CYC < 0) ? 0 : WAIT_CYC);
    localparam int CW = cnt_width(WAIT_EFF);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_EFF);

    // DEPTH held one bit wider than the address so DEPTH = 2**ADDR_W is
    // representable and the comparison cannot overflow.
    localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

    dmem_state_t state;
    dmem_state_t state_nxt;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_one;
    logic              enter_resp;

    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_oor;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    dmem_ws_counter #(
        .W (CW)
    ) u_ws_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (WAIT_LOAD),
        .one      (cnt_one)
    );

    // State register. Reset aborts whatever access is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A request is only looked at in IDLE, so anything
    // the master does while an access is running is ignored. With no wait
    // states the controller goes straight from IDLE to RESP.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    cnt_load  = 1'b1;
                    state_nxt = (WAIT_EFF > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_one) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture. The fields are held for the whole access so the
    // master may change its inputs as soon as it has been accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // The RAM access happens on the edge entering RESP. Without wait states
    // that edge is also the accept edge, so the live request fields are
    // used while still in IDLE and the latched ones otherwise.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state == IDLE) begin
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
        end
    end

    assign enter_resp = (state != RESP) && (state_nxt == RESP);
    assign acc_oor    = ({1'b0, acc_addr} >= DEPTH_LIM);

    // RAM write port. Contents survive reset; rst gating keeps a request
    // presented during reset from committing a write.
    always_ff @(posedge clk) begin
        if (enter_resp && rst && acc_we && !acc_oor) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    // Response registers. err is only ever high during RESP. rdata changes
    // only on a completed read (forced to zero when out of range) and
    // otherwise keeps the last read value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= enter_resp && acc_oor;
            if (enter_resp && !acc_we) begin
                rdata_q <= acc_oor ? '0 : mem[acc_addr];
            end
        end
    end

    assign ready = (state == IDLE);
    assign done  = (state == RESP);
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
//   Directed bench for dmem_ctrl. Three instances share clock, reset and
//   request fields, each with its own req line:
//     0: WAIT_CYC=2, DEPTH=256
//     1: WAIT_CYC=0, DEPTH=256
//     2: WAIT_CYC=2, DEPTH=200
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

    logic            clk;
    logic            rst;
    logic [2:0]      req_v;
    logic            we;
    logic [7:0]      addr;
    logic [7:0]      wdata;
    logic [2:0]      ready_v;
    logic [2:0]      done_v;
    logic [2:0]      err_v;
    logic [2:0][7:0] rdata_v;

    int num_applied;
    int num_miscompares;

    typedef struct {
        int         inst;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl [NVEC];

    dmem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYC(2)) u_dut_ws2 (
        .clk(clk), .rst(rst), .req(req_v[0]), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready_v[0]), .done(done_v[0]), .rdata(rdata_v[0]), .err(err_v[0])
    );

    dmem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYC(0)) u_dut_ws0 (
        .clk(clk), .rst(rst), .req(req_v[1]), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready_v[1]), .done(done_v[1]), .rdata(rdata_v[1]), .err(err_v[1])
    );

    dmem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .WAIT_CYC(2)) u_dut_d200 (
        .clk(clk), .rst(rst), .req(req_v[2]), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready_v[2]), .done(done_v[2]), .rdata(rdata_v[2]), .err(err_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_applied++;
        if (act !== exp) begin
            num_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete access: wait for ready, present the request for one
    // accepting edge, then follow it to its done pulse and back to idle.
    task automatic applyStimulus(input vec_t v, input int idx);
        int         waited;
        int         lat;
        bit         got;
        bit         busy_ready;
        logic [7:0] r;
        logic       e;
        @(negedge clk);
        we    = v.we;
        addr  = v.addr;
        wdata = v.wdata;
        req_v[v.inst] = 1'b1;
        waited = 0;
        while (ready_v[v.inst] !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput($sformatf("v%0d accept", idx), {31'd0, ready_v[v.inst]}, 32'd1);
        if (ready_v[v.inst] === 1'b1) begin
            @(posedge clk);
            #1;
            req_v[v.inst] = 1'b0;
            got        = 1'b0;
            lat        = 0;
            busy_ready = 1'b0;
            r          = 8'h00;
            e          = 1'b0;
            // The value seen #1 after edge N+k-1 is what edge N+k samples.
            for (int k = 1; k <= 40 && !got; k++) begin
                if (ready_v[v.inst] !== 1'b0) busy_ready = 1'b1;
                if (done_v[v.inst] === 1'b1) begin
                    got = 1'b1;
                    lat = k;
                    r   = rdata_v[v.inst];
                    e   = err_v[v.inst];
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
            checkOutput($sformatf("v%0d latency", idx), lat, v.exp_lat);
            checkOutput($sformatf("v%0d ready_busy", idx), {31'd0, busy_ready}, 32'd0);
            checkOutput($sformatf("v%0d err", idx), {31'd0, e}, {31'd0, v.exp_err});
            checkOutput($sformatf("v%0d rdata", idx), {24'd0, r}, {24'd0, v.exp_rdata});
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d done_once", idx), {31'd0, done_v[v.inst]}, 32'd0);
            checkOutput($sformatf("v%0d ready_back", idx), {31'd0, ready_v[v.inst]}, 32'd1);
        end else begin
            req_v[v.inst] = 1'b0;
        end
    endtask

    initial begin
        int         ndone;
        logic [7:0] r;
        vec_t       v;

        num_applied     = 0;
        num_miscompares = 0;
        rst   = 1'b0;
        req_v = 3'b000;
        we    = 1'b0;
        addr  = 8'h00;
        wdata = 8'h00;

        //            inst we    addr    wdata  exp_rd  err   lat
        tbl[0]  = '{0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, 3};
        tbl[1]  = '{0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 3};
        tbl[2]  = '{0, 1'b1, 8'h20, 8'h77, 8'hA5, 1'b0, 3};
        tbl[3]  = '{0, 1'b0, 8'h20, 8'h00, 8'h77, 1'b0, 3};
        tbl[4]  = '{0, 1'b1, 8'h33, 8'h11, 8'h77, 1'b0, 3};
        tbl[5]  = '{0, 1'b1, 8'hFF, 8'h99, 8'h77, 1'b0, 3};
        tbl[6]  = '{0, 1'b0, 8'hFF, 8'h00, 8'h99, 1'b0, 3};
        tbl[7]  = '{0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 3};
        tbl[8]  = '{1, 1'b1, 8'h05, 8'h5A, 8'h00, 1'b0, 1};
        tbl[9]  = '{1, 1'b0, 8'h05, 8'h00, 8'h5A, 1'b0, 1};
        tbl[10] = '{1, 1'b1, 8'h06, 8'hC3, 8'h5A, 1'b0, 1};
        tbl[11] = '{1, 1'b0, 8'h06, 8'h00, 8'hC3, 1'b0, 1};
        tbl[12] = '{2, 1'b1, 8'd200, 8'hFF, 8'h00, 1'b1, 3};
        tbl[13] = '{2, 1'b0, 8'd200, 8'h00, 8'h00, 1'b1, 3};
        tbl[14] = '{2, 1'b1, 8'd199, 8'h42, 8'h00, 1'b0, 3};
        tbl[15] = '{2, 1'b0, 8'd199, 8'h00, 8'h42, 1'b0, 3};
        tbl[16] = '{2, 1'b0, 8'd255, 8'h00, 8'h00, 1'b1, 3};
        tbl[17] = '{2, 1'b0, 8'd199, 8'h00, 8'h42, 1'b0, 3};

        // Reset for two cycles, then check the idle outputs.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("reset ready", {31'd0, ready_v[0]}, 32'd1);
        checkOutput("reset done", {31'd0, done_v[0]}, 32'd0);
        checkOutput("reset err", {31'd0, err_v[0]}, 32'd0);
        checkOutput("reset rdata", {24'd0, rdata_v[0]}, 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(tbl[i], i);
        end

        // Zero wait states, read held on req: accept every second edge.
        @(negedge clk);
        req_v[1] = 1'b1;
        we       = 1'b0;
        addr     = 8'h05;
        r        = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput($sformatf("b2b ready %0d", i), {31'd0, ready_v[1]}, (i % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("b2b done %0d", i), {31'd0, done_v[1]}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (done_v[1] === 1'b1) r = rdata_v[1];
        end
        req_v[1] = 1'b0;
        checkOutput("b2b rdata", {24'd0, r}, 32'h5A);
        @(negedge clk);
        @(negedge clk);

        // Reset during the wait states of a write: dropped, no done.
        @(negedge clk);
        req_v[0] = 1'b1;
        we       = 1'b1;
        addr     = 8'h20;
        wdata    = 8'h3C;
        @(posedge clk);
        #1;
        req_v[0] = 1'b0;
        checkOutput("abort busy", {31'd0, ready_v[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort ready", {31'd0, ready_v[0]}, 32'd1);
        checkOutput("abort done", {31'd0, done_v[0]}, 32'd0);
        checkOutput("abort rdata", {24'd0, rdata_v[0]}, 32'd0);
        @(negedge clk);
        rst   = 1'b1;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_v[0] !== 1'b0) ndone++;
        end
        checkOutput("abort no_done", ndone, 0);
        v = '{0, 1'b0, 8'h20, 8'h00, 8'h77, 1'b0, 3};
        applyStimulus(v, 100);

        // Request pulsed while busy: ignored, one done, original address.
        @(negedge clk);
        req_v[0] = 1'b1;
        we       = 1'b0;
        addr     = 8'h10;
        @(posedge clk);
        #1;
        checkOutput("busy_req accepted", {31'd0, ready_v[0]}, 32'd0);
        ndone = 0;
        r     = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 3) begin
                req_v[0] = 1'b1;
                we       = 1'b1;
                addr     = 8'h33;
                wdata    = 8'hEE;
            end else begin
                req_v[0] = 1'b0;
            end
            if (done_v[0] === 1'b1) begin
                ndone++;
                r = rdata_v[0];
            end
        end
        checkOutput("busy_req done_count", ndone, 1);
        checkOutput("busy_req rdata", {24'd0, r}, 32'hA5);
        v = '{0, 1'b0, 8'h33, 8'h00, 8'h11, 1'b0, 3};
        applyStimulus(v, 101);

        $display("== %0d vectors applied, %0d miscompares ==", num_applied, num_miscompares);
        $finish;
    end

endmodule
